// File: rtl/req_grant_dispatch_3_pkg.sv
// Shared arbitration types for the three-way request/grant dispatcher:
// FSM state encodings, owner codes and owner/grant helpers.
package nd120_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_1    = 2'd1;
  localparam logic [1:0] OWN_2    = 2'd2;
  localparam logic [1:0] OWN_3    = 2'd3;

  // One-hot grant vector {g3,g2,g1} for an owner code; none maps to all-zero.
  function automatic logic [2:0] owner_grant(input logic [1:0] own);
    case (own)
      OWN_1:   return 3'b001;
      OWN_2:   return 3'b010;
      OWN_3:   return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] next_owner(input logic [1:0] own);
    if (own == OWN_3 || own == OWN_NONE) begin
      return OWN_1;
    end
    return own + 2'd1;
  endfunction

endpackage

// File: rtl/req_grant_dispatch_3_if.sv
// Request/grant bundle between the three requesters and the dispatcher.
// master = requester side, slave = dispatcher side.
interface req_grant_dispatch_3_if;
  logic       req1;
  logic       req2;
  logic       req3;
  logic       grant1;
  logic       grant2;
  logic       grant3;
  logic [1:0] owner;
  logic       busy;
  logic       timeout;
  logic       any_req;

  modport master (
    output req1, req2, req3,
    input  grant1, grant2, grant3, owner, busy, timeout, any_req
  );

  modport slave (
    input  req1, req2, req3,
    output grant1, grant2, grant3, owner, busy, timeout, any_req
  );
endinterface

// File: rtl/req_grant_dispatch_3_rr_pick_3.sv
// Combinational round-robin picker: first active request after 'last',
// wrapping 1..3; returns OWN_NONE when nobody requests.
module rr_pick_3
  import nd120_arb_pkg::*;
(
  input  logic [2:0] r,
  input  logic [1:0] last,
  output logic [1:0] winner
);

  logic [1:0] cand1;
  logic [1:0] cand2;
  logic [1:0] cand3;

  assign cand1 = next_owner(last);
  assign cand2 = next_owner(cand1);
  assign cand3 = next_owner(cand2);

  // Lowest priority is tested first so the highest-priority hit overrides it.
  always_comb begin
    winner = OWN_NONE;
    if (|(r & owner_grant(cand3))) winner = cand3;
    if (|(r & owner_grant(cand2))) winner = cand2;
    if (|(r & owner_grant(cand1))) winner = cand1;
  end

endmodule

// File: rtl/req_grant_dispatch_3.sv
// Three-way round-robin request/grant dispatcher with per-input polarity
// mask, bounded ownership (hold timeout) and a dead cycle between owners.
module req_grant_dispatch_3
  import nd120_arb_pkg::*;
#(
  parameter logic [2:0]  BUBBLES_MASK = 3'b000,
  parameter int unsigned HOLD_MAX     = 255,
  parameter int unsigned CNT_W        = 16
) (
  input logic                   clock,
  input logic                   reset,
  req_grant_dispatch_3_if.slave bus
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  state_e           state_q, state_d;
  logic [1:0]       owner_q, owner_d;
  logic [1:0]       last_q, last_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [2:0]       grant_q, grant_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;

  logic [2:0]       r;
  logic [1:0]       winner;
  logic             r_own;

  assign r     = {bus.req3, bus.req2, bus.req1} ^ BUBBLES_MASK;
  assign r_own = |(r & owner_grant(owner_q));

  rr_pick_3 u_pick (
    .r      (r),
    .last   (last_q),
    .winner (winner)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    grant_d    = grant_q;
    timeout_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|r) begin
          owner_d    = winner;
          grant_d    = owner_grant(winner);
          hold_cnt_d = '0;
          state_d    = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // A still-requesting owner at the limit is a forced release; a drop wins.
        if (!r_own || hold_cnt_q == HOLD_LAST) begin
          owner_d   = OWN_NONE;
          grant_d   = 3'b000;
          last_d    = owner_q;
          state_d   = ST_RELEASE;
          timeout_d = r_own;
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
        grant_d = 3'b000;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_NONE;
      last_q     <= OWN_3;
      hold_cnt_q <= '0;
      grant_q    <= 3'b000;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.grant1  = grant_q[0];
  assign bus.grant2  = grant_q[1];
  assign bus.grant3  = grant_q[2];
  assign bus.owner   = owner_q;
  assign bus.busy    = busy_q;
  assign bus.timeout = timeout_q;
  assign bus.any_req = |r;

endmodule

// File: tb/tb_req_grant_dispatch_3.sv
// Bench for req_grant_dispatch_3: three instances (HOLD 255 / HOLD 4 /
// mask 101 with HOLD 1) share one raw request vector and a behavioural model.
module tb_req_grant_dispatch_3;
  import nd120_arb_pkg::*;

  logic       clock;
  logic       reset_s;
  logic [2:0] req_raw;

  int tests_run    = 0;
  int tests_failed = 0;

  int         hold_tab [3] = '{255, 4, 1};
  logic [2:0] mask_tab [3] = '{3'b000, 3'b000, 3'b101};

  // Behavioural model: owner 0 = nobody, count = grant cycles served so far.
  int m_owner [3];
  int m_count [3];
  int m_last  [3];
  bit m_dead  [3];
  bit m_to    [3];

  req_grant_dispatch_3_if bus0 ();
  req_grant_dispatch_3_if bus1 ();
  req_grant_dispatch_3_if bus2 ();

  assign bus0.req1 = req_raw[0];
  assign bus0.req2 = req_raw[1];
  assign bus0.req3 = req_raw[2];
  assign bus1.req1 = req_raw[0];
  assign bus1.req2 = req_raw[1];
  assign bus1.req3 = req_raw[2];
  assign bus2.req1 = req_raw[0];
  assign bus2.req2 = req_raw[1];
  assign bus2.req3 = req_raw[2];

  req_grant_dispatch_3 #(.BUBBLES_MASK(3'b000), .HOLD_MAX(255), .CNT_W(16)) u_dut0 (
    .clock (clock), .reset (reset_s), .bus (bus0));
  req_grant_dispatch_3 #(.BUBBLES_MASK(3'b000), .HOLD_MAX(4), .CNT_W(16)) u_dut1 (
    .clock (clock), .reset (reset_s), .bus (bus1));
  req_grant_dispatch_3 #(.BUBBLES_MASK(3'b101), .HOLD_MAX(1), .CNT_W(16)) u_dut2 (
    .clock (clock), .reset (reset_s), .bus (bus2));

  logic [2:0] act_grant [3];
  logic [1:0] act_owner [3];
  logic       act_busy  [3];
  logic       act_to    [3];
  logic       act_any   [3];

  assign act_grant[0] = {bus0.grant3, bus0.grant2, bus0.grant1};
  assign act_grant[1] = {bus1.grant3, bus1.grant2, bus1.grant1};
  assign act_grant[2] = {bus2.grant3, bus2.grant2, bus2.grant1};
  assign act_owner[0] = bus0.owner;
  assign act_owner[1] = bus1.owner;
  assign act_owner[2] = bus2.owner;
  assign act_busy[0]  = bus0.busy;
  assign act_busy[1]  = bus1.busy;
  assign act_busy[2]  = bus2.busy;
  assign act_to[0]    = bus0.timeout;
  assign act_to[1]    = bus1.timeout;
  assign act_to[2]    = bus2.timeout;
  assign act_any[0]   = bus0.any_req;
  assign act_any[1]   = bus1.any_req;
  assign act_any[2]   = bus2.any_req;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [2:0] got, input logic [2:0] exp);
    tests_run++;
    assert (got === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      logic [2:0] exp_g;
      logic [2:0] r;
      exp_g = (m_owner[k] == 0) ? 3'b000 : 3'(1 << (m_owner[k] - 1));
      r     = req_raw ^ mask_tab[k];
      checkOutput($sformatf("dut%0d.grant", k), act_grant[k], exp_g);
      checkOutput($sformatf("dut%0d.owner", k), {1'b0, act_owner[k]}, 3'(m_owner[k]));
      checkOutput($sformatf("dut%0d.busy", k), {2'b00, act_busy[k]},
                  {2'b00, (m_owner[k] != 0) || m_dead[k]});
      checkOutput($sformatf("dut%0d.timeout", k), {2'b00, act_to[k]}, {2'b00, m_to[k]});
      checkOutput($sformatf("dut%0d.any_req", k), {2'b00, act_any[k]}, {2'b00, |r});
      checkOutput($sformatf("dut%0d.onehot", k), {2'b00, $onehot0(act_grant[k])}, 3'b001);
    end
  endtask

  task automatic model_step(input logic [2:0] req_v, input logic rst_v);
    for (int k = 0; k < 3; k++) begin
      logic [2:0] r;
      r = req_v ^ mask_tab[k];
      if (rst_v) begin
        m_owner[k] = 0; m_count[k] = 0; m_dead[k] = 0; m_last[k] = 3; m_to[k] = 0;
      end else if (m_dead[k]) begin
        m_dead[k] = 0;
        m_to[k]   = 0;
      end else if (m_owner[k] == 0) begin
        for (int s = 1; s <= 3; s++) begin
          int c;
          c = (m_last[k] + s - 1) % 3 + 1;
          if (m_owner[k] == 0 && r[c-1]) begin
            m_owner[k] = c;
            m_count[k] = 1;
          end
        end
      end else if (!r[m_owner[k]-1]) begin
        m_last[k] = m_owner[k]; m_owner[k] = 0; m_dead[k] = 1;
      end else if (m_count[k] == hold_tab[k]) begin
        m_last[k] = m_owner[k]; m_owner[k] = 0; m_dead[k] = 1; m_to[k] = 1;
      end else begin
        m_count[k]++;
      end
    end
  endtask

  // Drive one cycle: inputs after the edge, check mid-cycle, then advance.
  task automatic applyStimulus(input logic [2:0] req_v, input logic rst_v);
    req_raw = req_v;
    reset_s = rst_v;
    @(negedge clock);
    check_all();
    model_step(req_v, rst_v);
    @(posedge clock);
    #1;
  endtask

  initial begin
    int         to_seen;
    int         prev_owner;
    int         owners [$];
    logic [2:0] rq;
    logic       rs;

    req_raw = 3'b000;
    reset_s = 1'b1;
    @(posedge clock);
    #1;
    model_step(3'b000, 1'b1);

    // Reset state
    applyStimulus(3'b000, 1'b1);
    applyStimulus(3'b000, 1'b0);

    // Test 1: req2 for five cycles on the HOLD 255 instance
    for (int i = 0; i < 5; i++) applyStimulus(3'b010, 1'b0);
    checkOutput("t1.grant2_held", {2'b00, bus0.grant2}, 3'b001);
    checkOutput("t1.owner2", {1'b0, bus0.owner}, 3'd2);
    applyStimulus(3'b000, 1'b0);
    checkOutput("t1.release_grant", act_grant[0], 3'b000);
    checkOutput("t1.release_busy", {2'b00, bus0.busy}, 3'b001);
    checkOutput("t1.release_to", {2'b00, bus0.timeout}, 3'b000);
    applyStimulus(3'b000, 1'b0);
    checkOutput("t1.idle_busy", {2'b00, bus0.busy}, 3'b000);
    applyStimulus(3'b000, 1'b0);

    // Test 2: all request, HOLD 4 instance rotates 1,2,3,1 with four timeouts
    applyStimulus(3'b000, 1'b1);
    to_seen    = 0;
    prev_owner = 0;
    for (int i = 0; i < 24; i++) begin
      applyStimulus(3'b111, 1'b0);
      if (bus1.timeout) to_seen++;
      if (prev_owner == 0 && bus1.owner != 2'd0) owners.push_back(int'(bus1.owner));
      prev_owner = int'(bus1.owner);
    end
    checkOutput("t2.timeouts", 3'(to_seen), 3'd4);
    checkOutput("t2.owner_cnt", 3'(owners.size()), 3'd4);
    if (owners.size() == 4) begin
      checkOutput("t2.order0", 3'(owners[0]), 3'd1);
      checkOutput("t2.order1", 3'(owners[1]), 3'd2);
      checkOutput("t2.order2", 3'(owners[2]), 3'd3);
      checkOutput("t2.order3", 3'(owners[3]), 3'd1);
    end

    // Test 3: raw req3 only; mask 101 turns it into requester 1
    for (int i = 0; i < 4; i++) begin
      applyStimulus(3'b100, 1'b0);
      checkOutput("t3.grant23", {1'b0, bus2.grant3, bus2.grant2}, 3'b000);
      checkOutput("t3.any_req", {2'b00, bus2.any_req}, 3'b001);
    end

    // Test 4: owner 1 drops on its last allowed cycle (HOLD 4 instance)
    applyStimulus(3'b000, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(3'b111, 1'b0);
    applyStimulus(3'b110, 1'b0);
    checkOutput("t4.no_timeout", {2'b00, bus1.timeout}, 3'b000);
    applyStimulus(3'b110, 1'b0);
    applyStimulus(3'b110, 1'b0);
    checkOutput("t4.next_owner", {1'b0, bus1.owner}, 3'd2);

    // Test 5: reset while requester 3 owns the HOLD 255 instance
    applyStimulus(3'b000, 1'b1);
    applyStimulus(3'b100, 1'b0);
    applyStimulus(3'b100, 1'b0);
    checkOutput("t5.owner3", {1'b0, bus0.owner}, 3'd3);
    applyStimulus(3'b111, 1'b1);
    checkOutput("t5.rst_grant", act_grant[0], 3'b000);
    checkOutput("t5.rst_busy", {bus0.busy, bus0.timeout, 1'b0}, 3'b000);
    applyStimulus(3'b111, 1'b0);
    checkOutput("t5.first_owner", {1'b0, bus0.owner}, 3'd1);

    // Test 6: requester 2 toggles while requester 1 owns
    applyStimulus(3'b000, 1'b1);
    for (int i = 0; i < 10; i++) begin
      applyStimulus((i % 2 == 0) ? 3'b001 : 3'b011, 1'b0);
      checkOutput("t6.grant_stable", act_grant[0], 3'b001);
    end

    // Random phase: requests held for a few cycles, occasional reset
    rq = 3'b000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) rq = 3'($urandom_range(0, 7));
      rs = ($urandom_range(0, 99) == 0);
      applyStimulus(rq, rs);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
